// File: rtl/roi_pkg.sv
// ROI crop control: shared coordinate layout, FSM states, rectangle type and
// the coordinate packing helper used by the shadow registers.
package roi_pkg;

   localparam int X_MSB   = 26;
   localparam int X_LSB   = 16;
   localparam int Y_MSB   = 9;
   localparam int Y_LSB   = 0;
   localparam int X_W     = X_MSB - X_LSB + 1;
   localparam int Y_W     = Y_MSB - Y_LSB + 1;
   localparam int COORD_W = 32;

   typedef enum logic [1:0] {
      UNSYNC = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2
   } roi_state_t;

   typedef struct packed {
      logic [X_W-1:0] x0;
      logic [Y_W-1:0] y0;
      logic [X_W-1:0] x1;
      logic [Y_W-1:0] y1;
   } roi_rect_t;

   function automatic logic [COORD_W-1:0] pack_xy(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
      logic [COORD_W-1:0] w_word;
      w_word              = '0;
      w_word[X_MSB:X_LSB] = x;
      w_word[Y_MSB:Y_LSB] = y;
      return w_word;
   endfunction

endpackage

// File: rtl/roi_cfg_norm.sv
// Combinational check of a corner pair against the frame, ordering into
// top-left / bottom-right and the resulting pixel count of the rectangle.
module roi_cfg_norm
   import roi_pkg::*;
#(
   parameter int WIDTH     = 800,
   parameter int HEIGHT    = 600,
   parameter int BIT_COORD = 32,
   parameter int AW        = 19
) (
   input  logic [BIT_COORD-1:0] i_xy_a,
   input  logic [BIT_COORD-1:0] i_xy_b,
   output logic                 o_valid,
   output roi_rect_t            o_rect,
   output logic [AW-1:0]        o_area
);

   localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT);

   logic [X_W-1:0] w_xa, w_xb;
   logic [Y_W-1:0] w_ya, w_yb;
   logic [AW-1:0]  w_dx, w_dy;
   logic           w_unused;

   assign w_xa = i_xy_a[X_MSB:X_LSB];
   assign w_xb = i_xy_b[X_MSB:X_LSB];
   assign w_ya = i_xy_a[Y_MSB:Y_LSB];
   assign w_yb = i_xy_b[Y_MSB:Y_LSB];

   // Coordinates are 1-based; zero is reserved to mean "crop disabled".
   assign o_valid = (w_xa != '0) && (w_xa <= X_MAX) && (w_xb != '0) && (w_xb <= X_MAX) &&
                    (w_ya != '0) && (w_ya <= Y_MAX) && (w_yb != '0) && (w_yb <= Y_MAX);

   assign o_rect.x0 = (w_xa < w_xb) ? w_xa : w_xb;
   assign o_rect.x1 = (w_xa < w_xb) ? w_xb : w_xa;
   assign o_rect.y0 = (w_ya < w_yb) ? w_ya : w_yb;
   assign o_rect.y1 = (w_ya < w_yb) ? w_yb : w_ya;

   assign w_dx   = AW'(o_rect.x1) - AW'(o_rect.x0) + AW'(1);
   assign w_dy   = AW'(o_rect.y1) - AW'(o_rect.y0) + AW'(1);
   assign o_area = AW'(w_dx * w_dy);

   assign w_unused = ^{i_xy_a[BIT_COORD-1:X_MSB+1], i_xy_a[X_LSB-1:Y_MSB+1],
                       i_xy_b[BIT_COORD-1:X_MSB+1], i_xy_b[X_LSB-1:Y_MSB+1]};

endmodule

// File: rtl/roi_frame_ctrl.sv
// ROI crop sequencer: holds a pending ROI, swaps it into the shadow only on a
// full-frame boundary, and monitors both streams for length/tlast errors.
module roi_frame_ctrl
   import roi_pkg::*;
#(
   parameter int WIDTH     = 800,
   parameter int HEIGHT    = 600,
   parameter int BIT_COORD = 32,
   parameter int BIT_CNT   = 16
) (
   input  logic                 clk_i,
   input  logic                 arst_ni,
   input  logic                 cfg_wr_i,
   input  logic [BIT_COORD-1:0] cfg_xy0_i,
   input  logic [BIT_COORD-1:0] cfg_xy1_i,
   input  logic                 clr_i,
   input  logic                 s_tvalid_i,
   input  logic                 s_tlast_i,
   input  logic                 r_tvalid_i,
   input  logic                 r_tlast_i,
   output logic [BIT_COORD-1:0] xy_0_o,
   output logic [BIT_COORD-1:0] xy_1_o,
   output logic                 roi_active_o,
   output logic                 cfg_pend_o,
   output logic                 frame_done_o,
   output logic [BIT_CNT-1:0]   frame_cnt_o,
   output logic [2:0]           stat_o
);

   localparam int            FRAME_N    = WIDTH * HEIGHT;
   localparam int            AW         = $clog2(FRAME_N + 1);
   localparam logic [AW-1:0] FRAME_LAST = AW'(FRAME_N - 1);

   roi_state_t           r_state;
   roi_rect_t            r_pend;
   logic                 r_pend_vld;
   logic [AW-1:0]        r_pend_area;
   logic [BIT_COORD-1:0] r_xy_0, r_xy_1;
   logic                 r_roi_active;
   logic [AW-1:0]        r_exp_cnt;
   logic [AW-1:0]        r_beat_cnt;
   logic [AW-1:0]        r_roi_cnt;
   logic                 r_frame_done;
   logic [BIT_CNT-1:0]   r_frame_cnt;
   logic [2:0]           r_stat;

   logic          w_norm_vld;
   roi_rect_t     w_norm_rect;
   logic [AW-1:0] w_norm_area;

   roi_cfg_norm #(
      .WIDTH    (WIDTH),
      .HEIGHT   (HEIGHT),
      .BIT_COORD(BIT_COORD),
      .AW       (AW)
   ) u_norm (
      .i_xy_a (cfg_xy0_i),
      .i_xy_b (cfg_xy1_i),
      .o_valid(w_norm_vld),
      .o_rect (w_norm_rect),
      .o_area (w_norm_area)
   );

   logic          w_wr_ok, w_cfg_err, w_synced, w_at_last, w_frame_end, w_frm_err;
   logic          w_boundary, w_ld_vld, w_apply, w_roi_beat, w_roi_err;
   roi_rect_t     w_ld_rect;
   logic [AW-1:0] w_ld_area, w_roi_next, w_roi_now;

   assign w_wr_ok   = cfg_wr_i & w_norm_vld;
   assign w_cfg_err = cfg_wr_i & ~w_norm_vld;

   // A write landing on the boundary edge bypasses the pending slot.
   assign w_ld_vld  = w_wr_ok | r_pend_vld;
   assign w_ld_rect = w_wr_ok ? w_norm_rect : r_pend;
   assign w_ld_area = w_wr_ok ? w_norm_area : r_pend_area;

   assign w_synced    = (r_state != UNSYNC);
   assign w_at_last   = (r_beat_cnt == FRAME_LAST);
   assign w_frame_end = s_tvalid_i & (s_tlast_i | (w_synced & w_at_last));
   assign w_frm_err   = w_synced & s_tvalid_i & (s_tlast_i ^ w_at_last);

   // SYNC applies on an idle cycle before the first beat, or at the next frame end.
   assign w_boundary = ((r_state == SYNC) & (((r_beat_cnt == '0) & ~s_tvalid_i) | w_frame_end)) |
                       ((r_state == ACTIVE) & w_frame_end);
   assign w_apply    = w_boundary & w_ld_vld;

   assign w_roi_beat = (r_state == ACTIVE) & r_tvalid_i;
   assign w_roi_next = r_roi_cnt + AW'(1);
   assign w_roi_now  = w_roi_beat ? w_roi_next : r_roi_cnt;
   assign w_roi_err  = (w_roi_beat & (r_tlast_i ^ (w_roi_next == r_exp_cnt))) |
                       ((r_state == ACTIVE) & w_frame_end & (w_roi_now != r_exp_cnt));

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_state      <= UNSYNC;
         r_pend       <= '0;
         r_pend_vld   <= 1'b0;
         r_pend_area  <= '0;
         r_xy_0       <= '0;
         r_xy_1       <= '0;
         r_roi_active <= 1'b0;
         r_exp_cnt    <= '0;
         r_beat_cnt   <= '0;
         r_roi_cnt    <= '0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
         r_stat       <= '0;
      end else begin
         r_frame_done <= 1'b0;
         r_stat       <= (clr_i ? 3'b000 : r_stat) | {w_roi_err, w_frm_err, w_cfg_err};

         if (s_tvalid_i)
            r_beat_cnt <= w_frame_end ? '0 : r_beat_cnt + AW'(1);

         if (w_frame_end)
            r_roi_cnt <= '0;
         else if (w_roi_beat)
            r_roi_cnt <= w_roi_next;

         if (w_synced & w_frame_end) begin
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + BIT_CNT'(1);
         end

         if (w_apply) begin
            r_xy_0       <= BIT_COORD'(pack_xy(w_ld_rect.x0, w_ld_rect.y0));
            r_xy_1       <= BIT_COORD'(pack_xy(w_ld_rect.x1, w_ld_rect.y1));
            r_exp_cnt    <= w_ld_area;
            r_roi_active <= 1'b1;
            r_pend_vld   <= 1'b0;
         end else if (w_wr_ok) begin
            r_pend      <= w_norm_rect;
            r_pend_area <= w_norm_area;
            r_pend_vld  <= 1'b1;
         end

         case (r_state)
            UNSYNC:  if (s_tvalid_i & s_tlast_i) r_state <= SYNC;
            SYNC:    if (w_apply) r_state <= ACTIVE;
            ACTIVE:  r_state <= ACTIVE;
            default: r_state <= UNSYNC;
         endcase
      end
   end

   assign xy_0_o       = r_xy_0;
   assign xy_1_o       = r_xy_1;
   assign roi_active_o = r_roi_active;
   assign cfg_pend_o   = r_pend_vld;
   assign frame_done_o = r_frame_done;
   assign frame_cnt_o  = r_frame_cnt;
   assign stat_o       = r_stat;

endmodule

// File: tb/tb_roi_frame_ctrl.sv
// Scoreboard bench for roi_frame_ctrl on a reduced 16x24 frame: expected
// per-frame results are queued by the stimulus and checked on frame_done_o.
module tb_roi_frame_ctrl;

   localparam int W  = 16;
   localparam int H  = 24;
   localparam int N  = W * H;
   localparam int CW = 3;

   logic          clk_i = 1'b0;
   logic          arst_ni;
   logic          cfg_wr_i, clr_i;
   logic [31:0]   cfg_xy0_i, cfg_xy1_i;
   logic          s_tvalid_i, s_tlast_i, r_tvalid_i, r_tlast_i;
   logic [31:0]   xy_0_o, xy_1_o;
   logic          roi_active_o, cfg_pend_o, frame_done_o;
   logic [CW-1:0] frame_cnt_o;
   logic [2:0]    stat_o;

   roi_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .BIT_COORD(32), .BIT_CNT(CW)) dut (
      .clk_i(clk_i), .arst_ni(arst_ni), .cfg_wr_i(cfg_wr_i), .cfg_xy0_i(cfg_xy0_i),
      .cfg_xy1_i(cfg_xy1_i), .clr_i(clr_i), .s_tvalid_i(s_tvalid_i), .s_tlast_i(s_tlast_i),
      .r_tvalid_i(r_tvalid_i), .r_tlast_i(r_tlast_i), .xy_0_o(xy_0_o), .xy_1_o(xy_1_o),
      .roi_active_o(roi_active_o), .cfg_pend_o(cfg_pend_o), .frame_done_o(frame_done_o),
      .frame_cnt_o(frame_cnt_o), .stat_o(stat_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [CW-1:0] cnt;
      logic [31:0]   a;
      logic [31:0]   b;
      logic [2:0]    st;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [31:0] pk(input int x, input int y);
      return (32'(x) << 16) | 32'(y);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic push_exp(input int cnt, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] st);
      exp_t e;
      e.cnt = CW'(cnt);
      e.a   = a;
      e.b   = b;
      e.st  = st;
      sb_q.push_back(e);
   endtask

   // Monitor: every frame_done pulse must match the oldest queued expectation.
   always @(negedge clk_i) begin
      if (frame_done_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame: unexpected frame_done cnt=%0d, none expected", frame_cnt_o);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("frame", 128'({frame_cnt_o, xy_0_o, xy_1_o, stat_o}), 128'(e));
         end
      end
   end

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      cfg_wr_i   = 1'b0;
      clr_i      = 1'b0;
      s_tvalid_i = 1'b0;
      s_tlast_i  = 1'b0;
      r_tvalid_i = 1'b0;
      r_tlast_i  = 1'b0;
   endtask

   task automatic clear_stat();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      check("stat_clr", 128'(stat_o), 128'(3'b000));
   endtask

   // nb full-frame beats back to back; ROI stub emits roi_n beats with tlast on
   // beat roi_last (1-based); optional write at beat wr_at. A mid-frame write is
   // checked to be held pending while the shadow stays at mid_xy0.
   task automatic run_frame(input int nb, input bit with_last, input int roi_n,
                            input int roi_last, input int wr_at, input logic [31:0] wa,
                            input logic [31:0] wb, input logic [31:0] mid_xy0);
      for (int k = 0; k < nb; k++) begin
         s_tvalid_i = 1'b1;
         s_tlast_i  = with_last && (k == nb - 1);
         r_tvalid_i = (k < roi_n);
         r_tlast_i  = (roi_last > 0) && (k == roi_last - 1);
         cfg_wr_i   = (k == wr_at);
         cfg_xy0_i  = wa;
         cfg_xy1_i  = wb;
         if (wr_at >= 0 && wr_at < nb - 1 && k == nb - 1) begin
            check("mid_xy0_frozen", 128'(xy_0_o), 128'(mid_xy0));
            check("mid_pend", 128'(cfg_pend_o), 128'(1'b1));
         end
         tick();
      end
      idle();
   endtask

   logic [31:0] bad_a[3];
   logic [31:0] bad_b[3];

   initial begin
      idle();
      cfg_xy0_i = '0;
      cfg_xy1_i = '0;
      arst_ni   = 1'b0;
      repeat (3) tick();
      check("reset_xy", 128'({xy_0_o, xy_1_o}), 128'(0));
      check("reset_flags", 128'({roi_active_o, cfg_pend_o, frame_done_o, frame_cnt_o, stat_o}), 128'(0));
      arst_ni = 1'b1;
      tick();

      // First write held pending until the stream is synchronised.
      cfg_wr_i  = 1'b1;
      cfg_xy0_i = pk(10, 20);
      cfg_xy1_i = pk(5, 8);
      tick();
      cfg_wr_i = 1'b0;
      check("t1_pend", 128'(cfg_pend_o), 128'(1'b1));
      check("t1_xy0_unsync", 128'(xy_0_o), 128'(0));
      s_tvalid_i = 1'b1;
      s_tlast_i  = 1'b1;
      tick();
      idle();
      tick();
      check("t1_applied", 128'({xy_0_o, xy_1_o}), 128'({pk(5, 8), pk(10, 20)}));
      check("t1_flags", 128'({roi_active_o, cfg_pend_o, frame_cnt_o}), 128'({1'b1, 1'b0, 3'd0}));

      // Out-of-range writes: cfg_err only, nothing else moves.
      bad_a[0] = pk(0, 5);  bad_b[0] = pk(3, 5);
      bad_a[1] = pk(3, 25); bad_b[1] = pk(3, 5);
      bad_a[2] = pk(17, 2); bad_b[2] = pk(1, 1);
      for (int i = 0; i < 3; i++) begin
         cfg_wr_i  = 1'b1;
         cfg_xy0_i = bad_a[i];
         cfg_xy1_i = bad_b[i];
         tick();
         cfg_wr_i = 1'b0;
         check("bad_stat", 128'(stat_o), 128'(3'b001));
         check("bad_keep", 128'({cfg_pend_o, xy_0_o, xy_1_o}), 128'({1'b0, pk(5, 8), pk(10, 20)}));
         clear_stat();
      end
      // Error set wins over a simultaneous clear.
      cfg_wr_i = 1'b1;
      clr_i    = 1'b1;
      tick();
      idle();
      check("clr_vs_set", 128'(stat_o), 128'(3'b001));
      clear_stat();

      // Mid-frame write with swapped corners; applied at the frame end.
      push_exp(1, pk(1, 1), pk(4, 3), 3'b000);
      run_frame(N, 1'b1, 78, 78, 100, pk(4, 3), pk(1, 1), pk(5, 8));
      check("f1_pend_clr", 128'(cfg_pend_o), 128'(1'b0));

      // ROI of 12 pixels, crop emits only 11.
      push_exp(2, pk(1, 1), pk(4, 3), 3'b100);
      run_frame(N, 1'b1, 11, 11, -1, '0, '0, '0);
      clear_stat();

      // Correct 12-beat ROI plus a write coincident with the last beat.
      push_exp(3, pk(2, 3), pk(7, 9), 3'b000);
      run_frame(N, 1'b1, 12, 12, N - 1, pk(7, 3), pk(2, 9), '0);
      check("bypass_no_pend", 128'(cfg_pend_o), 128'(1'b0));

      push_exp(4, pk(2, 3), pk(7, 9), 3'b000);
      run_frame(N, 1'b1, 42, 42, -1, '0, '0, '0);

      // tlast one beat early.
      push_exp(5, pk(2, 3), pk(7, 9), 3'b010);
      run_frame(N - 1, 1'b1, 42, 42, -1, '0, '0, '0);
      clear_stat();

      // Full count without tlast is forced to be the frame end.
      push_exp(6, pk(2, 3), pk(7, 9), 3'b010);
      run_frame(N, 1'b0, 42, 42, -1, '0, '0, '0);
      clear_stat();

      push_exp(7, pk(2, 3), pk(7, 9), 3'b000);
      run_frame(N, 1'b1, 42, 42, -1, '0, '0, '0);
      push_exp(0, pk(2, 3), pk(7, 9), 3'b000);
      run_frame(N, 1'b1, 42, 42, -1, '0, '0, '0);

      // Asynchronous reset in the middle of a frame.
      s_tvalid_i = 1'b1;
      repeat (50) tick();
      #3;
      arst_ni = 1'b0;
      #1;
      check("mid_rst_xy", 128'({xy_0_o, xy_1_o}), 128'(0));
      check("mid_rst_flags", 128'({roi_active_o, cfg_pend_o, frame_done_o, frame_cnt_o, stat_o}), 128'(0));
      idle();
      tick();
      arst_ni = 1'b1;
      tick();
      run_frame(N + 16, 1'b0, 0, 0, -1, '0, '0, '0);
      check("unsync_quiet", 128'({xy_0_o, roi_active_o, frame_cnt_o, stat_o}), 128'(0));
      run_frame(1, 1'b1, 0, 0, -1, '0, '0, '0);
      tick();
      check("sync_no_count", 128'({frame_cnt_o, stat_o}), 128'(0));
      push_exp(1, '0, '0, 3'b000);
      run_frame(N, 1'b1, 0, 0, -1, '0, '0, '0);

      repeat (4) tick();
      check("sb_drain", 128'(sb_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
